score_display_driver: RTL
=========================

// Module: score_display_driver
// PURPOSE
//   Consumes the 4-bit saturating score (0..10) from the score counter and drives a
//   4-digit common-anode 7-segment display, time-multiplexed. Shows score as two decimal
//   digits (digits 1,0), flags each score change with a DP flash, blinks on the winning
//   score 10. Sits between the score counter and the board's SEG/AN pins.
// PARAMETERS
//   REFRESH_DIV   50000  CLK cycles per digit slot (1 kHz/digit at 50 MHz); >=2
//   FLASH_TICKS   250    refresh ticks DP stays lit after a score change
//   BLINK_TICKS   500    refresh ticks per half-period of win blink
// PORTS
//   CLK      in   1  system clock, all logic on posedge
//   RESET_N  in   1  asynchronous, active-low reset
//   SCORE    in   4  current score from score counter; legal 0..10
//   AN_N     out  4  digit anodes, active low, AN_N[0] = rightmost digit
//   SEG_N    out  7  segments {g,f,e,d,c,b,a}, active low
//   DP_N     out  1  decimal point, active low
// BEHAVIOUR
//   Reset (async assert, sync release): AN_N=4'b1111, SEG_N=7'h7F, DP_N=1, prescaler=0,
//     strobe=0, state=SHOW, timers=0, score_q=0, score_prev=0.
//   Input: SCORE registered into score_q every cycle; score_prev <= score_q. change = (score_q != score_prev).
//   Prescaler: 0..REFRESH_DIV-1, wraps; tick=1 for the single cycle count==REFRESH_DIV-1.
//   Strobe: 2-bit, +1 on tick, 3->0 wrap. Slot s drives digit s.
//   Digit values: score_q<10 -> tens=blank, units=score_q; score_q==10 -> tens=1, units=0;
//     score_q 11..15 -> both digits show dash (SEG_N=7'b0111111). Digits 3,2 always blank.
//   Blank digit: its anode stays 1 in its slot (all AN_N=1111 in that slot).
//   Patterns: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010
//     6=0000010 7=1111000 8=0000000 9=0010000.
//   FSM (state updates every cycle):
//     SHOW : change & score_q==10 -> WIN; change & score_q!=10 -> FLASH (flash_cnt=0).
//     FLASH: DP_N=0 on digit 0 slot. flash_cnt +1 per tick. score_q==10 -> WIN;
//            another change -> stay FLASH, flash_cnt=0; flash_cnt==FLASH_TICKS-1 & tick -> SHOW.
//     WIN  : blink_cnt +1 per tick, wrap at BLINK_TICKS-1 toggling blink_off (starts 0);
//            blink_off=1 forces AN_N=1111. score_q!=10 -> SHOW (no flash), blink cnt/flag cleared.
//   Simultaneous change and timer expiry in FLASH: change wins (restart). Change to 0
//     (counter reset) flashes as any other change.
//   Outputs registered: AN_N/SEG_N/DP_N update together, one cycle after strobe/state.
//     New SCORE visible on its digit slot within REFRESH_DIV*4+3 cycles.
//   Anode, segment and DP never drive a non-selected digit; exactly <=1 AN_N bit low.
//   Reset mid-operation: all outputs to reset values immediately (async), FSM to SHOW.
// STRUCTURE
//   Package score_display_pkg: seg pattern constants SEG_0..SEG_9, SEG_BLANK, SEG_DASH,
//     state enum {SHOW, FLASH, WIN} (2-bit), digit-index width.
//   Sub-module score_seg7_decoder: combinational 4-bit digit code (0..9, blank, dash) -> SEG_N.
//   Top: prescaler, strobe, input regs, FSM + timers, output regs.
// TESTING (bench params REFRESH_DIV=4, FLASH_TICKS=3, BLINK_TICKS=2)
//   Reset with SCORE=5 held -> AN_N=1111, SEG_N=7F, DP_N=1 while RESET_N=0; first tick after
//     release strobe=1.
//   SCORE=7 steady -> slot0 AN_N=1110 SEG_N=1111000; slots 1-3 AN_N=1111; DP_N=1 after flash.
//   SCORE 3->4 -> DP_N=0 in slot0 for 3 ticks (12 cycles), then SHOW; 4->5 at tick 2 restarts.
//   SCORE=10 -> slot1 AN_N=1101 SEG_N=1111001, slot0 SEG_N=1000000; every 2 ticks AN_N
//     forced 1111 for 2 ticks; SCORE->0 returns SHOW, no DP.
//   SCORE=12 -> slots 0,1 SEG_N=0111111, no blink.
//   RESET_N low mid-FLASH and mid-WIN (asynchronous to CLK) -> outputs reset same
//     instant; after release state=SHOW, flash/blink counters 0.

Source files
------------

// File: rtl/score_display_pkg.sv
// Shared constants for the score display driver.
//   - SEG_* : active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
//   - CODE_*: 4-bit digit codes fed to the segment decoder (0..9, blank, dash)
//   - state_t: display mode FSM encoding
//   - DIGIT_W: width of the digit-slot index (4 digits)
package score_display_pkg;

   localparam int DIGIT_W = 2;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   localparam logic [3:0] CODE_BLANK = 4'hA;
   localparam logic [3:0] CODE_DASH  = 4'hB;

   typedef enum logic [1:0] {
      SHOW  = 2'd0,
      FLASH = 2'd1,
      WIN   = 2'd2
   } state_t;

endpackage

// File: rtl/score_seg7_decoder.sv
// Combinational digit-code to 7-segment decoder.
//   code  : 0..9 digit, CODE_BLANK, or CODE_DASH (other codes decode blank)
//   seg_n : active-low segments {g,f,e,d,c,b,a}
module score_seg7_decoder
   import score_display_pkg::*;
(
   input  logic [3:0] code,
   output logic [6:0] seg_n
);

   always_comb begin
      seg_n = SEG_BLANK;
      case (code)
         4'd0:      seg_n = SEG_0;
         4'd1:      seg_n = SEG_1;
         4'd2:      seg_n = SEG_2;
         4'd3:      seg_n = SEG_3;
         4'd4:      seg_n = SEG_4;
         4'd5:      seg_n = SEG_5;
         4'd6:      seg_n = SEG_6;
         4'd7:      seg_n = SEG_7;
         4'd8:      seg_n = SEG_8;
         4'd9:      seg_n = SEG_9;
         CODE_DASH: seg_n = SEG_DASH;
         default:   seg_n = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/score_display_driver.sv
// Time-multiplexed 4-digit common-anode display driver for a 0..10 score.
// Shows the score on digits 1,0, lights digit-0 DP for FLASH_TICKS refresh
// ticks after any score change, and blinks the display while the score is 10.
//   CLK     : system clock
//   RESET_N : asynchronous active-low reset
//   SCORE   : score from the counter (legal 0..10, 11..15 shown as dashes)
//   AN_N    : digit anodes, active low, bit 0 = rightmost digit
//   SEG_N   : segments {g,f,e,d,c,b,a}, active low
//   DP_N    : decimal point, active low
module score_display_driver
   import score_display_pkg::*;
#(
   parameter int REFRESH_DIV = 50000,
   parameter int FLASH_TICKS = 250,
   parameter int BLINK_TICKS = 500
) (
   input  logic       CLK,
   input  logic       RESET_N,
   input  logic [3:0] SCORE,
   output logic [3:0] AN_N,
   output logic [6:0] SEG_N,
   output logic       DP_N
);

   localparam int PRE_W = $clog2(REFRESH_DIV);
   localparam int FL_W  = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;
   localparam int BL_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
   localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLASH_TICKS - 1);
   localparam logic [BL_W-1:0]  BL_LAST  = BL_W'(BLINK_TICKS - 1);

   logic [3:0]         score_q, score_prev;
   logic [PRE_W-1:0]   pre_cnt;
   logic [DIGIT_W-1:0] strobe;
   state_t             state, state_nxt;
   logic [FL_W-1:0]    flash_cnt, flash_nxt;
   logic [BL_W-1:0]    blink_cnt, blink_nxt;
   logic               blink_off, blink_off_nxt;
   logic               tick, change, is_win;

   assign tick   = (pre_cnt == PRE_LAST);
   assign change = (score_q != score_prev);
   assign is_win = (score_q == 4'd10);

   // Prescaler, digit strobe and input pipeline
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         pre_cnt    <= '0;
         strobe     <= '0;
         score_q    <= '0;
         score_prev <= '0;
      end else begin
         pre_cnt    <= tick ? '0 : pre_cnt + 1'b1;
         if (tick) strobe <= strobe + 1'b1;
         score_q    <= SCORE;
         score_prev <= score_q;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= SHOW;
         flash_cnt <= '0;
         blink_cnt <= '0;
         blink_off <= 1'b0;
      end else begin
         state     <= state_nxt;
         flash_cnt <= flash_nxt;
         blink_cnt <= blink_nxt;
         blink_off <= blink_off_nxt;
      end
   end

   // Mode FSM. Reaching 10 always wins over the flash; a fresh change while
   // flashing restarts the flash even on the tick that would have ended it.
   always_comb begin
      state_nxt     = state;
      flash_nxt     = flash_cnt;
      blink_nxt     = blink_cnt;
      blink_off_nxt = blink_off;
      case (state)
         SHOW: begin
            if (change) begin
               if (is_win) begin
                  state_nxt     = WIN;
                  blink_nxt     = '0;
                  blink_off_nxt = 1'b0;
               end else begin
                  state_nxt = FLASH;
                  flash_nxt = '0;
               end
            end
         end
         FLASH: begin
            if (is_win) begin
               state_nxt     = WIN;
               flash_nxt     = '0;
               blink_nxt     = '0;
               blink_off_nxt = 1'b0;
            end else if (change) begin
               flash_nxt = '0;
            end else if (tick) begin
               if (flash_cnt == FL_LAST) begin
                  state_nxt = SHOW;
                  flash_nxt = '0;
               end else begin
                  flash_nxt = flash_cnt + 1'b1;
               end
            end
         end
         WIN: begin
            if (!is_win) begin
               state_nxt     = SHOW;
               blink_nxt     = '0;
               blink_off_nxt = 1'b0;
            end else if (tick) begin
               if (blink_cnt == BL_LAST) begin
                  blink_nxt     = '0;
                  blink_off_nxt = ~blink_off;
               end else begin
                  blink_nxt = blink_cnt + 1'b1;
               end
            end
         end
         default: state_nxt = SHOW;
      endcase
   end

   // Digit selection for the current slot
   logic [3:0] units_code, tens_code, slot_code;
   logic [6:0] seg_dec;
   logic       lit;

   always_comb begin
      units_code = score_q;
      tens_code  = CODE_BLANK;
      if (is_win) begin
         units_code = 4'd0;
         tens_code  = 4'd1;
      end else if (score_q > 4'd10) begin
         units_code = CODE_DASH;
         tens_code  = CODE_DASH;
      end
      case (strobe)
         2'd0:    slot_code = units_code;
         2'd1:    slot_code = tens_code;
         default: slot_code = CODE_BLANK;
      endcase
   end

   score_seg7_decoder u_dec (
      .code  (slot_code),
      .seg_n (seg_dec)
   );

   // A dark slot drives nothing: no anode, no segments, no DP
   assign lit = (slot_code != CODE_BLANK) && !(state == WIN && blink_off);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         AN_N  <= 4'b1111;
         SEG_N <= SEG_BLANK;
         DP_N  <= 1'b1;
      end else begin
         AN_N  <= lit ? ~(4'b0001 << strobe) : 4'b1111;
         SEG_N <= lit ? seg_dec : SEG_BLANK;
         DP_N  <= ~(lit && state == FLASH && strobe == 2'd0);
      end
   end

endmodule
